// File: rtl/piso_arbiter_if.sv
// Requester handshakes and serial output of the two-requester PISO arbiter,
// bundled so the bench and the design share one set of named signals.
interface piso_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       sout;
   logic       frame;
   logic       grant_id;
   logic       done;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, sout, frame, grant_id, done
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, sout, frame, grant_id, done
   );
endinterface

// File: rtl/piso_arbiter.sv
// Two-requester round-robin arbiter feeding an 8-bit MSB-first serialiser,
// with GAP idle cycles inserted after every frame.
module piso_arbiter #(
   parameter int unsigned GAP = 1
) (
   input logic           clk,
   input logic           rst,
   piso_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] shreg;
   logic [2:0] cnt;
   logic [3:0] gap_cnt;
   logic       grant_q;
   logic       last_grant;
   logic       winner;
   logic       handshake;

   // NOTE: every signal driven here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      winner         = 1'b0;
      handshake      = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.sout       = 1'b0;
      bus.frame      = 1'b0;
      bus.done       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!rst) begin
               // On contention the requester that did not win last time goes next.
               if (bus.req0_valid && bus.req1_valid) winner = ~last_grant;
               else                                  winner = bus.req1_valid;
               bus.req0_ready = bus.req0_valid && !winner;
               bus.req1_ready = bus.req1_valid &&  winner;
               handshake      = bus.req0_ready || bus.req1_ready;
               if (handshake) state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bus.sout  = shreg[7];
            bus.frame = 1'b1;
            if (cnt == 3'd7) begin
               // A reset landing on the last bit aborts the frame, so it gets no done.
               bus.done   = !rst;
               state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= 8'h00;
         cnt        <= 3'd0;
         gap_cnt    <= 4'd0;
         grant_q    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  shreg      <= winner ? bus.req1_data : bus.req0_data;
                  cnt        <= 3'd0;
                  gap_cnt    <= 4'd0;
                  grant_q    <= winner;
                  last_grant <= winner;
               end
            end
            ST_SHIFT: begin
               shreg   <= {shreg[6:0], 1'b0};
               gap_cnt <= 4'd0;
               if (cnt != 3'd7) cnt <= cnt + 3'd1;
            end
            ST_GAP: begin
               if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_piso_arbiter.sv
// Drives three arbiters (GAP = 1, 0, 3) with shared stimulus and compares every
// output each cycle against a timeline model of the frame schedule.
module tb_piso_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1;
   logic [7:0] d0, d1;

   always #5 clk = ~clk;

   piso_arbiter_if bus_g1 ();
   piso_arbiter_if bus_g0 ();
   piso_arbiter_if bus_g3 ();

   piso_arbiter #(.GAP(1)) u_g1 (.clk(clk), .rst(rst), .bus(bus_g1));
   piso_arbiter #(.GAP(0)) u_g0 (.clk(clk), .rst(rst), .bus(bus_g0));
   piso_arbiter #(.GAP(3)) u_g3 (.clk(clk), .rst(rst), .bus(bus_g3));

   assign bus_g1.req0_valid = v0;
   assign bus_g1.req0_data  = d0;
   assign bus_g1.req1_valid = v1;
   assign bus_g1.req1_data  = d1;
   assign bus_g0.req0_valid = v0;
   assign bus_g0.req0_data  = d0;
   assign bus_g0.req1_valid = v1;
   assign bus_g0.req1_data  = d1;
   assign bus_g3.req0_valid = v0;
   assign bus_g3.req0_data  = d0;
   assign bus_g3.req1_valid = v1;
   assign bus_g3.req1_data  = d1;

   logic o_r0 [3];
   logic o_r1 [3];
   logic o_sout [3];
   logic o_frame [3];
   logic o_gid [3];
   logic o_done [3];

   assign o_r0[0] = bus_g1.req0_ready;  assign o_r0[1] = bus_g0.req0_ready;  assign o_r0[2] = bus_g3.req0_ready;
   assign o_r1[0] = bus_g1.req1_ready;  assign o_r1[1] = bus_g0.req1_ready;  assign o_r1[2] = bus_g3.req1_ready;
   assign o_sout[0] = bus_g1.sout;      assign o_sout[1] = bus_g0.sout;      assign o_sout[2] = bus_g3.sout;
   assign o_frame[0] = bus_g1.frame;    assign o_frame[1] = bus_g0.frame;    assign o_frame[2] = bus_g3.frame;
   assign o_gid[0] = bus_g1.grant_id;   assign o_gid[1] = bus_g0.grant_id;   assign o_gid[2] = bus_g3.grant_id;
   assign o_done[0] = bus_g1.done;      assign o_done[1] = bus_g0.done;      assign o_done[2] = bus_g3.done;

   // Model: 'since' counts cycles after the accepting edge (0 = idle);
   // 1..8 carry bits 7..0, 9..8+gap are gap cycles.
   int         gap_of [3] = '{1, 0, 3};
   int         since  [3];
   logic [7:0] byte_q [3];
   logic       last_q [3];
   logic       gid_q  [3];
   logic       e_r0   [3];
   logic       e_r1   [3];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   bit count_readys = 0;
   int r0_pulses, r1_pulses;
   bit track_done = 0;
   int last_done_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs();
      for (int n = 0; n < 3; n++) begin
         bit   idle, in_frame, w;
         logic e_sout;
         string pfx;
         pfx      = $sformatf("gap%0d", gap_of[n]);
         idle     = (since[n] == 0);
         in_frame = (since[n] >= 1) && (since[n] <= 8);
         e_r0[n]  = 1'b0;
         e_r1[n]  = 1'b0;
         if (idle && !rst) begin
            if (v0 && v1) begin
               w       = !last_q[n];
               e_r0[n] = !w;
               e_r1[n] = w;
            end else begin
               e_r0[n] = v0;
               e_r1[n] = v1 && !v0;
            end
         end
         e_sout = in_frame ? byte_q[n][8 - since[n]] : 1'b0;
         check({pfx, " req0_ready"}, 32'(o_r0[n]), 32'(e_r0[n]));
         check({pfx, " req1_ready"}, 32'(o_r1[n]), 32'(e_r1[n]));
         check({pfx, " sout"},       32'(o_sout[n]), 32'(e_sout));
         check({pfx, " frame"},      32'(o_frame[n]), 32'(in_frame));
         check({pfx, " done"},       32'(o_done[n]), 32'(since[n] == 8 && !rst));
         check({pfx, " grant_id"},   32'(o_gid[n]), 32'(gid_q[n]));
      end
   endtask

   task automatic update_model();
      for (int n = 0; n < 3; n++) begin
         if (rst) begin
            since[n]  = 0;
            byte_q[n] = 8'h00;
            last_q[n] = 1'b1;
            gid_q[n]  = 1'b0;
         end else if (since[n] == 0) begin
            if (e_r0[n] || e_r1[n]) begin
               since[n]  = 1;
               byte_q[n] = e_r1[n] ? d1 : d0;
               gid_q[n]  = e_r1[n];
               last_q[n] = e_r1[n];
            end
         end else begin
            since[n]++;
            if (since[n] > 8 + gap_of[n]) since[n] = 0;
         end
      end
   endtask

   task automatic cycle(input logic r, input logic nv0, input logic [7:0] nd0,
                        input logic nv1, input logic [7:0] nd1);
      @(negedge clk);
      rst = r;
      v0  = nv0;
      d0  = nd0;
      v1  = nv1;
      d1  = nd1;
      #1;
      check_outputs();
      if (count_readys) begin
         if (o_r0[0]) r0_pulses++;
         if (o_r1[0]) r1_pulses++;
      end
      if (track_done && o_done[1]) begin
         if (last_done_cyc >= 0) check("gap0 done spacing", 32'(cyc - last_done_cyc), 32'd9);
         last_done_cyc = cyc;
      end
      @(posedge clk);
      update_model();
      cyc++;
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b1, 8'hAA, 1'b1, 8'h55);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      d0  = 8'h00;
      d1  = 8'h00;
      for (int n = 0; n < 3; n++) begin
         since[n]  = 0;
         byte_q[n] = 8'h00;
         last_q[n] = 1'b1;
         gid_q[n]  = 1'b0;
         e_r0[n]   = 1'b0;
         e_r1[n]   = 1'b0;
      end
      @(posedge clk);
      do_reset();

      // Single requester 0 sending 0F.
      cycle(1'b0, 1'b1, 8'h0F, 1'b0, 8'h00);
      idle_cycles(14);

      // Both held valid for four GAP=1 frames: A5 first, then 3C, alternating.
      do_reset();
      r0_pulses    = 0;
      r1_pulses    = 0;
      count_readys = 1;
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'hA5, 1'b1, 8'h3C);
      count_readys = 0;
      check("gap1 req0_ready pulses", 32'(r0_pulses), 32'd2);
      check("gap1 req1_ready pulses", 32'(r1_pulses), 32'd2);
      idle_cycles(12);

      // Reset in cycle T+4 of an FF frame, then req1 alone sends 81.
      do_reset();
      cycle(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
      idle_cycles(3);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      idle_cycles(4);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h81);
      idle_cycles(14);

      // Continuous req1 with 55: GAP=0 instance finishes a frame every 9 cycles.
      do_reset();
      last_done_cyc = -1;
      track_done    = 1;
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h55);
      track_done = 0;
      check("gap0 saw done", 32'(last_done_cyc >= 0), 32'd1);
      idle_cycles(12);

      // Data changes right after the handshake do not reach the frame.
      do_reset();
      cycle(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      idle_cycles(13);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), 8'($urandom),
               ($urandom_range(3) != 0), 8'($urandom));
      end
      idle_cycles(14);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
